// File: rtl/ray_bounce_scheduler_pkg.sv
// Shared fixed-point ray types and scheduler state encoding for the trace loop.
// Vectors are Q8.8 per channel; ray_slot_t is the payload launched into the intersector.
package ray_bounce_scheduler_pkg;

    localparam int FP_BITS      = 16;
    localparam int FP_VEC3_BITS = 3 * FP_BITS;

    typedef logic [FP_BITS-1:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } fp_vec3;

    typedef fp_vec3 fp_color;

    localparam fp FP_ONE = 16'h0100;

    // Slot field widths match the scheduler's default PIX_BITS / BNC_BITS.
    localparam int SLOT_PIX_BITS = 16;
    localparam int SLOT_BNC_BITS = 3;

    typedef struct packed {
        logic [SLOT_PIX_BITS-1:0] pix;
        logic [SLOT_BNC_BITS-1:0] bounce;
        fp_vec3                   origin;
        fp_vec3                   dir;
        fp_color                  color;
        fp_vec3                   light;
    } ray_slot_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_RUN   = 2'd1,
        SCHED_DRAIN = 2'd2
    } sched_state_e;

    function automatic fp_color color_one();
        return '{x: FP_ONE, y: FP_ONE, z: FP_ONE};
    endfunction

endpackage

// File: rtl/ray_sched_if.sv
// Ray traffic around the scheduler: camera rays in, loop returns in, issue and retire out.
// new_* is valid/ready (transfer when both high); ret_*, issue_* and retire_* are valid-only, no backpressure.
interface ray_sched_if #(
    parameter int PIX_BITS = 16,
    parameter int BNC_BITS = 3
) ();
    import ray_bounce_scheduler_pkg::*;

    logic                    new_valid;
    logic                    new_ready;
    logic                    new_last;
    logic [PIX_BITS-1:0]     new_pix;
    logic [FP_VEC3_BITS-1:0] new_origin;
    logic [FP_VEC3_BITS-1:0] new_dir;

    logic                    ret_valid;
    logic                    ret_hit;
    logic [PIX_BITS-1:0]     ret_pix;
    logic [BNC_BITS-1:0]     ret_bounce;
    logic [FP_VEC3_BITS-1:0] ret_origin;
    logic [FP_VEC3_BITS-1:0] ret_dir;
    logic [FP_VEC3_BITS-1:0] ret_color;
    logic [FP_VEC3_BITS-1:0] ret_light;

    logic                    issue_valid;
    logic [PIX_BITS-1:0]     issue_pix;
    logic [BNC_BITS-1:0]     issue_bounce;
    logic [FP_VEC3_BITS-1:0] issue_origin;
    logic [FP_VEC3_BITS-1:0] issue_dir;
    logic [FP_VEC3_BITS-1:0] issue_color;
    logic [FP_VEC3_BITS-1:0] issue_light;

    logic                    retire_valid;
    logic [PIX_BITS-1:0]     retire_pix;
    logic [FP_VEC3_BITS-1:0] retire_light;

    modport master (
        output new_valid, new_last, new_pix, new_origin, new_dir,
        input  new_ready,
        output ret_valid, ret_hit, ret_pix, ret_bounce, ret_origin, ret_dir, ret_color, ret_light,
        input  issue_valid, issue_pix, issue_bounce, issue_origin, issue_dir, issue_color, issue_light,
        input  retire_valid, retire_pix, retire_light
    );

    modport slave (
        input  new_valid, new_last, new_pix, new_origin, new_dir,
        output new_ready,
        input  ret_valid, ret_hit, ret_pix, ret_bounce, ret_origin, ret_dir, ret_color, ret_light,
        output issue_valid, issue_pix, issue_bounce, issue_origin, issue_dir, issue_color, issue_light,
        output retire_valid, retire_pix, retire_light
    );

endinterface

// File: rtl/ray_bounce_scheduler_inflight_counter.sv
// Up/down count of rays resident in the trace loop; never wraps below zero or past the cap.
module ray_inflight_counter #(
    parameter int MAX_COUNT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic full_o
);

    localparam int              CW    = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0]   MAX_C = CW'(MAX_COUNT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && count_q != MAX_C) begin
            count_d = count_q + CW'(1);
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    assign full_o = (count_q >= MAX_C);

endmodule

// File: rtl/ray_bounce_scheduler.sv
// Issue arbiter for the trace loop: returning rays always take the slot, camera rays fill gaps.
// Optional RAY_SCHED_STATS_EN adds saturating per-frame issue/retire/stall counters.
module ray_bounce_scheduler
    import ray_bounce_scheduler_pkg::*;
#(
    parameter int MAX_BOUNCES   = 4,
    parameter int MAX_IN_FLIGHT = 64,
    parameter int PIX_BITS      = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    ray_sched_if.slave   bus,
    output logic         busy,
    output logic         frame_done,
    output sched_state_e dbg_state_o
`ifdef RAY_SCHED_STATS_EN
    ,
    output logic [31:0]  stat_issued,
    output logic [31:0]  stat_retired,
    output logic [31:0]  stat_stall
`endif
);

    localparam int                BNC_BITS = $clog2(MAX_BOUNCES + 1);
    localparam logic [BNC_BITS:0] MAX_B    = (BNC_BITS + 1)'(MAX_BOUNCES);

    logic [1:0] state_q, state_d;
    logic       cnt_zero, cnt_full;
    logic       ret_take, recirc, retire, new_accept, new_ready;
    logic [BNC_BITS:0] nb;

    ray_slot_t               slot_q, slot_d;
    logic                    issue_valid_q, issue_valid_d;
    logic                    retire_valid_q, retire_valid_d;
    logic [PIX_BITS-1:0]     retire_pix_q, retire_pix_d;
    logic [FP_VEC3_BITS-1:0] retire_light_q, retire_light_d;
    logic                    frame_done_q, frame_done_d;

    // A return only counts while rays are resident; stale returns after reset or in IDLE vanish.
    assign ret_take   = bus.ret_valid && (state_q != S_IDLE) && !cnt_zero;
    assign nb         = {1'b0, bus.ret_bounce} + (BNC_BITS + 1)'(1);
    assign recirc     = ret_take && bus.ret_hit && (nb < MAX_B);
    assign retire     = ret_take && !recirc;
    assign new_ready  = (state_q == S_RUN) && !bus.ret_valid && !cnt_full;
    assign new_accept = bus.new_valid && new_ready;

    ray_inflight_counter #(
        .MAX_COUNT (MAX_IN_FLIGHT)
    ) u_inflight (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (new_accept),
        .dec_i  (retire),
        .zero_o (cnt_zero),
        .full_o (cnt_full)
    );

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) state_d = S_RUN;
            end
            S_RUN: begin
                if (new_accept && bus.new_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_zero && !bus.ret_valid) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // new_ready is low whenever ret_valid is high, so recirc and new_accept never coincide.
    always_comb begin
        slot_d         = slot_q;
        issue_valid_d  = recirc || new_accept;
        retire_valid_d = retire;
        retire_pix_d   = retire_pix_q;
        retire_light_d = retire_light_q;
        if (recirc) begin
            slot_d.pix    = SLOT_PIX_BITS'(bus.ret_pix);
            slot_d.bounce = SLOT_BNC_BITS'(nb);
            slot_d.origin = bus.ret_origin;
            slot_d.dir    = bus.ret_dir;
            slot_d.color  = bus.ret_color;
            slot_d.light  = bus.ret_light;
        end else if (new_accept) begin
            slot_d.pix    = SLOT_PIX_BITS'(bus.new_pix);
            slot_d.bounce = '0;
            slot_d.origin = bus.new_origin;
            slot_d.dir    = bus.new_dir;
            slot_d.color  = color_one();
            slot_d.light  = '0;
        end
        if (retire) begin
            retire_pix_d   = bus.ret_pix;
            retire_light_d = bus.ret_light;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            slot_q         <= '0;
            issue_valid_q  <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_pix_q   <= '0;
            retire_light_q <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            issue_valid_q  <= issue_valid_d;
            retire_valid_q <= retire_valid_d;
            retire_pix_q   <= retire_pix_d;
            retire_light_q <= retire_light_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.new_ready    = new_ready;
    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_pix    = PIX_BITS'(slot_q.pix);
    assign bus.issue_bounce = BNC_BITS'(slot_q.bounce);
    assign bus.issue_origin = slot_q.origin;
    assign bus.issue_dir    = slot_q.dir;
    assign bus.issue_color  = slot_q.color;
    assign bus.issue_light  = slot_q.light;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_pix   = retire_pix_q;
    assign bus.retire_light = retire_light_q;

    assign busy        = (state_q != S_IDLE);
    assign frame_done  = frame_done_q;
    assign dbg_state_o = sched_state_e'(state_q);

`ifdef RAY_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_retired_q, stat_stall_q;
    logic        stall;

    assign stall = (state_q == S_RUN) && bus.new_valid && !new_ready;

    // Counters restart when a frame actually begins and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || (state_q == S_IDLE && frame_start)) begin
            stat_issued_q  <= '0;
            stat_retired_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (issue_valid_d && stat_issued_q != '1) stat_issued_q <= stat_issued_q + 32'd1;
            if (retire && stat_retired_q != '1)       stat_retired_q <= stat_retired_q + 32'd1;
            if (stall && stat_stall_q != '1)          stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_retired = stat_retired_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_ray_bounce_scheduler.sv
// Directed bench for ray_bounce_scheduler with MAX_BOUNCES=4, MAX_IN_FLIGHT=4.
module tb_ray_bounce_scheduler;
    import ray_bounce_scheduler_pkg::*;

    localparam int PIX_BITS = 16;
    localparam int BNC_BITS = 3;
    localparam logic [FP_VEC3_BITS-1:0] ONE3  = {3{FP_ONE}};
    localparam logic [FP_VEC3_BITS-1:0] DIR0  = 48'h0000_0100_0000;
    localparam logic [FP_VEC3_BITS-1:0] COLR  = 48'h0080_0040_0020;
    localparam logic [FP_VEC3_BITS-1:0] RDIR  = 48'h0100_0000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic         busy;
    logic         frame_done;
    sched_state_e dbg_state;
`ifdef RAY_SCHED_STATS_EN
    logic [31:0]  stat_issued, stat_retired, stat_stall;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ray_sched_if #(.PIX_BITS(PIX_BITS), .BNC_BITS(BNC_BITS)) bus ();

    ray_bounce_scheduler #(
        .MAX_BOUNCES   (4),
        .MAX_IN_FLIGHT (4),
        .PIX_BITS      (PIX_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .bus          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .dbg_state_o  (dbg_state)
`ifdef RAY_SCHED_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_retired (stat_retired),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_start    = 1'b0;
        bus.new_valid  = 1'b0;
        bus.new_last   = 1'b0;
        bus.new_pix    = '0;
        bus.new_origin = '0;
        bus.new_dir    = '0;
        bus.ret_valid  = 1'b0;
        bus.ret_hit    = 1'b0;
        bus.ret_pix    = '0;
        bus.ret_bounce = '0;
        bus.ret_origin = '0;
        bus.ret_dir    = '0;
        bus.ret_color  = '0;
        bus.ret_light  = '0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_state", 64'(dbg_state), 64'(SCHED_RUN));
    endtask

    // Offer one camera ray; it must be accepted and issued with bounce 0, unit color, no light.
    task automatic send_new(input logic [15:0] pix, input logic last);
        bus.new_valid  = 1'b1;
        bus.new_last   = last;
        bus.new_pix    = pix;
        bus.new_origin = {pix, 16'h0200, pix};
        bus.new_dir    = DIR0;
        #1;
        check("new_ready", bus.new_ready, 1);
        tick();
        bus.new_valid = 1'b0;
        bus.new_last  = 1'b0;
        check("new_issue_valid", bus.issue_valid, 1);
        check("new_issue_pix", bus.issue_pix, pix);
        check("new_issue_bounce", bus.issue_bounce, 0);
        check("new_issue_color", bus.issue_color, ONE3);
        check("new_issue_light", bus.issue_light, 0);
        check("new_issue_origin", bus.issue_origin, {pix, 16'h0200, pix});
    endtask

    // Drive one loop return; exp_recirc says whether it should come back as an issue or a retire.
    task automatic send_ret(input logic [15:0] pix, input logic hit, input logic [2:0] bnc,
                            input logic [47:0] light, input logic exp_recirc, input logic [2:0] exp_bnc);
        bus.ret_valid  = 1'b1;
        bus.ret_hit    = hit;
        bus.ret_pix    = pix;
        bus.ret_bounce = bnc;
        bus.ret_origin = {16'h00A0, pix, 16'h0C00};
        bus.ret_dir    = RDIR;
        bus.ret_color  = COLR;
        bus.ret_light  = light;
        #1;
        check("ret_blocks_ready", bus.new_ready, 0);
        tick();
        bus.ret_valid = 1'b0;
        check("ret_issue_valid", bus.issue_valid, exp_recirc);
        check("ret_retire_valid", bus.retire_valid, !exp_recirc);
        if (exp_recirc) begin
            check("recirc_pix", bus.issue_pix, pix);
            check("recirc_bounce", bus.issue_bounce, exp_bnc);
            check("recirc_origin", bus.issue_origin, {16'h00A0, pix, 16'h0C00});
            check("recirc_dir", bus.issue_dir, RDIR);
            check("recirc_color", bus.issue_color, COLR);
            check("recirc_light", bus.issue_light, light);
        end else begin
            check("retire_pix", bus.retire_pix, pix);
            check("retire_light", bus.retire_light, light);
        end
    endtask

    // Called right after the last retire: frame_done follows one cycle later for one cycle.
    task automatic finish_frame();
        check("done_not_yet", frame_done, 0);
        tick();
        check("frame_done_pulse", frame_done, 1);
        check("done_busy", busy, 0);
        check("done_state", 64'(dbg_state), 64'(SCHED_IDLE));
        tick();
        check("frame_done_low", frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepts;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst_issue", bus.issue_valid, 0);
        check("rst_retire", bus.retire_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_ready", bus.new_ready, 0);
        check("rst_state", 64'(dbg_state), 64'(SCHED_IDLE));
        rst = 1'b0;
        tick();

        // Basic frame: three rays escape on their first return.
        start_frame();
        send_new(16'd10, 1'b0);
        send_new(16'd11, 1'b0);
        send_new(16'd12, 1'b1);
        check("drain_state", 64'(dbg_state), 64'(SCHED_DRAIN));
        send_ret(16'd10, 1'b0, 3'd0, 48'h0001_0002_0003, 1'b0, 3'd0);
        send_ret(16'd11, 1'b0, 3'd0, 48'h0004_0005_0006, 1'b0, 3'd0);
        send_ret(16'd12, 1'b0, 3'd0, 48'h0007_0008_0009, 1'b0, 3'd0);
        finish_frame();

        // Bounce depth: hit at bounce 0 recirculates, hit at bounce 3 is forced to retire.
        start_frame();
        send_new(16'd20, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("restart_ignored", 64'(dbg_state), 64'(SCHED_DRAIN));
        send_ret(16'd20, 1'b1, 3'd0, 48'h0010_0020_0030, 1'b1, 3'd1);
        send_ret(16'd20, 1'b1, 3'd3, 48'h0040_0050_0060, 1'b0, 3'd0);
        finish_frame();

        // Return and camera ray in the same cycle: the return wins, camera ray goes next cycle.
        start_frame();
        send_new(16'd30, 1'b0);
        bus.new_valid  = 1'b1;
        bus.new_last   = 1'b1;
        bus.new_pix    = 16'd31;
        send_ret(16'd30, 1'b1, 3'd0, 48'h0100_0200_0300, 1'b1, 3'd1);
        send_new(16'd31, 1'b1);
        send_ret(16'd30, 1'b0, 3'd1, 48'h0111_0222_0333, 1'b0, 3'd0);
        send_ret(16'd31, 1'b0, 3'd0, 48'h0444_0555_0666, 1'b0, 3'd0);
        finish_frame();

        // In-flight cap: holding new_valid yields exactly 4 accepts.
        start_frame();
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            bus.new_valid  = 1'b1;
            bus.new_last   = 1'b0;
            bus.new_pix    = 16'(40 + accepts);
            bus.new_origin = '0;
            bus.new_dir    = DIR0;
            #1;
            if (bus.new_ready) accepts++;
            tick();
        end
        bus.new_valid = 1'b1;
        #1;
        check("cap_accepts", accepts, 4);
        check("cap_ready_low", bus.new_ready, 0);
        bus.new_valid = 1'b0;
        send_ret(16'd40, 1'b0, 3'd0, 48'h0000_0000_0001, 1'b0, 3'd0);
        bus.new_valid = 1'b1;
        #1;
        check("cap_ready_after_retire", bus.new_ready, 1);
        bus.new_valid = 1'b0;
        send_new(16'd44, 1'b0);

        // Reset mid-frame with the loop full, then stale returns must do nothing.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", 64'(dbg_state), 64'(SCHED_IDLE));
        check("mid_rst_issue", bus.issue_valid, 0);
        for (int i = 0; i < 5; i++) begin
            bus.ret_valid  = 1'b1;
            bus.ret_hit    = i[0];
            bus.ret_pix    = 16'(41 + i);
            bus.ret_bounce = 3'd0;
            tick();
            check("stale_issue", bus.issue_valid, 0);
            check("stale_retire", bus.retire_valid, 0);
            check("stale_busy", busy, 0);
            check("stale_done", frame_done, 0);
        end
        bus.ret_valid = 1'b0;
        bus.new_valid = 1'b1;
        #1;
        check("idle_ready", bus.new_ready, 0);
        tick();
        check("idle_no_issue", bus.issue_valid, 0);
        bus.new_valid = 1'b0;
        tick();

`ifdef RAY_SCHED_STATS_EN
        // Ten rays, each returned one cycle after issue, hitting twice then escaping.
        begin
            int sent;
            bit done_seen;
            sent = 0;
            done_seen = 1'b0;
            start_frame();
            check("stat_issued_clr", stat_issued, 0);
            check("stat_retired_clr", stat_retired, 0);
            for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
                bus.ret_valid  = bus.issue_valid;
                bus.ret_pix    = bus.issue_pix;
                bus.ret_bounce = bus.issue_bounce;
                bus.ret_hit    = (bus.issue_bounce < 3'd2);
                bus.new_valid  = (sent < 10);
                bus.new_pix    = 16'(sent);
                bus.new_last   = (sent == 9);
                #1;
                if (bus.new_valid && bus.new_ready) sent++;
                tick();
                if (frame_done) done_seen = 1'b1;
            end
            idle_inputs();
            check("stats_frame_done", done_seen, 1);
            check("stat_issued", stat_issued, 30);
            check("stat_retired", stat_retired, 10);
            check("stat_stall_nonzero", stat_stall != 0, 1);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
